regfile_wb_arbiter: RTL

- Shares the register file's single write port between two writeback requesters: port A (ALU result) and port B (load data from memory).
- Each requester has a small FIFO. A round-robin arbiter pops one entry per cycle into a registered output stage, which drives regwrite, write_reg and write_data into the register file.
- Also provides a pending-write scoreboard, so decode can stall reads of registers that still have queued writes.

---
 rtl/regfile_wb_arbiter_if.sv | 33 +++
 rtl/regfile_wb_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus for regfile_wb_arbiter: two requester ports, the register-file
// write port and the decode hazard queries. The arbiter takes the slave modport.
interface regfile_wb_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          a_valid;
    logic          a_ready;
    logic [AW-1:0] a_reg;
    logic [DW-1:0] a_data;
    logic          b_valid;
    logic          b_ready;
    logic [AW-1:0] b_reg;
    logic [DW-1:0] b_data;
    logic          regwrite;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] write_data;
    logic [AW-1:0] query_reg1;
    logic [AW-1:0] query_reg2;
    logic          hazard1;
    logic          hazard2;
    logic          idle;

    modport master (
        output a_valid, a_reg, a_data, b_valid, b_reg, b_data, query_reg1, query_reg2,
        input  a_ready, b_ready, regwrite, write_reg, write_data, hazard1, hazard2, idle
    );

    modport slave (
        input  a_valid, a_reg, a_data, b_valid, b_reg, b_data, query_reg1, query_reg2,
        output a_ready, b_ready, regwrite, write_reg, write_data, hazard1, hazard2, idle
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between two FIFO'd
// requesters, with a pending-write scoreboard. Option: REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input logic                  clock,
    input logic                  reset,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic {PRIO_A, PRIO_B} prio_t;

    prio_t         prio;
    logic [AW-1:0] mem_reg  [2][DEPTH];
    logic [DW-1:0] mem_data [2][DEPTH];
    logic [PW-1:0] wr_ptr   [2];
    logic [PW-1:0] rd_ptr   [2];
    logic [CW-1:0] count    [2];

    logic          in_valid  [2];
    logic [AW-1:0] in_reg    [2];
    logic [DW-1:0] in_data   [2];
    logic          ready     [2];
    logic          bypass    [2];
    logic          cand      [2];
    logic          grant     [2];
    logic          push      [2];
    logic          pop       [2];
    logic [AW-1:0] head_reg  [2];
    logic [DW-1:0] head_data [2];

    logic          win_b;
    logic          any_grant;
    logic [AW-1:0] win_reg;
    logic [DW-1:0] win_data;
    logic          out_valid;
    logic [AW-1:0] out_reg;
    logic [DW-1:0] out_data;
    logic          hit1;
    logic          hit2;

    assign in_valid[0] = bus.a_valid;
    assign in_reg[0]   = bus.a_reg;
    assign in_data[0]  = bus.a_data;
    assign in_valid[1] = bus.b_valid;
    assign in_reg[1]   = bus.b_reg;
    assign in_data[1]  = bus.b_data;

    always_comb begin
        for (int unsigned r = 0; r < 2; r++) begin
            ready[r] = (count[r] != CW'(DEPTH));
`ifdef REGFILE_WB_BYPASS_EN
            // An accepted request into an empty FIFO competes in the same edge.
            bypass[r] = (count[r] == '0) && in_valid[r];
`else
            bypass[r] = 1'b0;
`endif
            cand[r]      = (count[r] != '0) || bypass[r];
            head_reg[r]  = bypass[r] ? in_reg[r]  : mem_reg[r][rd_ptr[r]];
            head_data[r] = bypass[r] ? in_data[r] : mem_data[r][rd_ptr[r]];
        end
        win_b     = cand[1] && (!cand[0] || prio == PRIO_B);
        any_grant = cand[0] || cand[1];
        grant[0]  = cand[0] && !win_b;
        grant[1]  = win_b;
        win_reg   = win_b ? head_reg[1]  : head_reg[0];
        win_data  = win_b ? head_data[1] : head_data[0];
        for (int unsigned r = 0; r < 2; r++) begin
            push[r] = in_valid[r] && ready[r] && !(bypass[r] && grant[r]);
            pop[r]  = grant[r] && !bypass[r];
        end
    end

    always_ff @(posedge clock) begin
        for (int unsigned r = 0; r < 2; r++) begin
            if (push[r]) begin
                mem_reg[r][wr_ptr[r]]  <= in_reg[r];
                mem_data[r][wr_ptr[r]] <= in_data[r];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < 2; r++) begin
                wr_ptr[r] <= '0;
                rd_ptr[r] <= '0;
                count[r]  <= '0;
            end
            prio      <= PRIO_A;
            out_valid <= 1'b0;
            out_reg   <= '0;
            out_data  <= '0;
        end else begin
            for (int unsigned r = 0; r < 2; r++) begin
                if (push[r]) wr_ptr[r] <= wr_ptr[r] + PW'(1);
                if (pop[r])  rd_ptr[r] <= rd_ptr[r] + PW'(1);
                count[r] <= count[r] + CW'(push[r]) - CW'(pop[r]);
            end
            // A register-0 winner is consumed and rotates priority but never writes.
            if (any_grant) begin
                prio      <= win_b ? PRIO_A : PRIO_B;
                out_valid <= (win_reg != '0);
                out_reg   <= win_reg;
                out_data  <= win_data;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        logic [PW-1:0] offset;
        offset = '0;
        hit1   = 1'b0;
        hit2   = 1'b0;
        for (int unsigned r = 0; r < 2; r++) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                offset = PW'(i) - rd_ptr[r];
                if ({1'b0, offset} < count[r]) begin
                    if (mem_reg[r][i] == bus.query_reg1) hit1 = 1'b1;
                    if (mem_reg[r][i] == bus.query_reg2) hit2 = 1'b1;
                end
            end
`ifdef REGFILE_WB_BYPASS_EN
            if (in_valid[r] && ready[r] && in_reg[r] == bus.query_reg1) hit1 = 1'b1;
            if (in_valid[r] && ready[r] && in_reg[r] == bus.query_reg2) hit2 = 1'b1;
`endif
        end
        if (out_valid && out_reg == bus.query_reg1) hit1 = 1'b1;
        if (out_valid && out_reg == bus.query_reg2) hit2 = 1'b1;
        if (bus.query_reg1 == '0) hit1 = 1'b0;
        if (bus.query_reg2 == '0) hit2 = 1'b0;
    end

    assign bus.a_ready    = ready[0];
    assign bus.b_ready    = ready[1];
    assign bus.regwrite   = out_valid;
    assign bus.write_reg  = out_reg;
    assign bus.write_data = out_data;
    assign bus.hazard1    = hit1;
    assign bus.hazard2    = hit2;
    assign bus.idle       = (count[0] == '0) && (count[1] == '0) && !out_valid;
endmodule
